// File: rtl/eth_tx_scheduler_if.sv
// Handshake bundle between the TX scheduler, its two dibit source FIFOs and the dibit packer.
// master = scheduler side, slave = FIFO/packer side.
interface eth_tx_scheduler_if #(
  parameter int unsigned CNT_W = 13
);
  logic [CNT_W-1:0] src0_count;
  logic             src0_empty;
  logic             src0_rd;
  logic [1:0]       src0_data;
  logic [CNT_W-1:0] src1_count;
  logic             src1_empty;
  logic             src1_rd;
  logic [1:0]       src1_data;
  logic             packer_stall;
  logic             packer_axiiv;
  logic [1:0]       packer_axiid;
  logic             packer_cancel;
  logic             busy;
  logic             active_src;
  logic             underflow_err;

  modport master (
    input  src0_count, src0_empty, src0_data,
    input  src1_count, src1_empty, src1_data,
    input  packer_stall,
    output src0_rd, src1_rd,
    output packer_axiiv, packer_axiid, packer_cancel,
    output busy, active_src, underflow_err
  );

  modport slave (
    output src0_count, src0_empty, src0_data,
    output src1_count, src1_empty, src1_data,
    output packer_stall,
    input  src0_rd, src1_rd,
    input  packer_axiiv, packer_axiid, packer_cancel,
    input  busy, active_src, underflow_err
  );
endinterface

// File: rtl/eth_tx_scheduler.sv
// Two-source round-robin scheduler feeding the Ethernet dibit packer: 4-dibit tag + payload per packet.
// Optional per-source packet / error counters are enabled with `define ETH_TX_SCHED_STATS_EN.
module eth_tx_scheduler #(
  parameter int unsigned PKT_DIBITS   = 5120,
  parameter int unsigned CNT_W        = 13,
  parameter int unsigned SLOT_TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  eth_tx_scheduler_if.master    bus
`ifdef ETH_TX_SCHED_STATS_EN
  ,
  output logic [15:0]           pkt_cnt0,
  output logic [15:0]           pkt_cnt1,
  output logic [7:0]            err_cnt
`endif
);

  localparam int unsigned KW    = $clog2(PKT_DIBITS + 1);
  localparam int unsigned TW    = $clog2(SLOT_TIMEOUT + 1);
  localparam int unsigned SEQ_W = 7;

  typedef enum logic [1:0] {IDLE, WAIT_SLOT, STREAM, DRAIN} state_e;

  state_e           state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_src_q, last_src_d;
  logic [SEQ_W-1:0] seq0_q, seq0_d, seq1_q, seq1_d;
  logic [KW-1:0]    beat_q, beat_d;
  logic [TW-1:0]    wait_q, wait_d;
  logic             cancel_q, cancel_d;
  logic             axiiv_q, axiiv_d;
  logic             pay_sel_q, pay_sel_d;
  logic [1:0]       tag_dib_q, tag_dib_d;
  logic             uerr_q, uerr_d;
  logic             busy_q, busy_d;

  logic       qual0_c, qual1_c, slot_c, payload_c, last_beat_c, cur_empty_c;
  logic       rd_c, done_c;
  logic [7:0] tag_c;
  logic [1:0] tag_sel_c;

  assign qual0_c     = bus.src0_count >= CNT_W'(PKT_DIBITS - 4);
  assign qual1_c     = bus.src1_count >= CNT_W'(PKT_DIBITS - 4);
  assign slot_c      = ~bus.packer_stall;
  assign payload_c   = beat_q >= KW'(4);
  assign last_beat_c = beat_q == KW'(PKT_DIBITS - 1);
  assign cur_empty_c = grant_q ? bus.src1_empty : bus.src0_empty;
  assign tag_c       = {grant_q, (grant_q ? seq1_q : seq0_q)};
  assign tag_sel_c   = tag_c[{beat_q[1:0], 1'b0} +: 2];
  assign done_c      = (state_q == DRAIN) && bus.packer_stall;

  // Reads are combinational from state, so they vanish the instant reset clears state_q.
  assign rd_c        = (state_q == STREAM) && slot_c && payload_c && !cur_empty_c;
  assign bus.src0_rd = rd_c && !grant_q;
  assign bus.src1_rd = rd_c && grant_q;

  assign bus.packer_axiiv  = axiiv_q;
  assign bus.packer_axiid  = pay_sel_q ? (grant_q ? bus.src1_data : bus.src0_data) : tag_dib_q;
  assign bus.packer_cancel = cancel_q;
  assign bus.busy          = busy_q;
  assign bus.active_src    = grant_q;
  assign bus.underflow_err = uerr_q;

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_src_d = last_src_q;
    seq0_d     = seq0_q;
    seq1_d     = seq1_q;
    beat_d     = beat_q;
    wait_d     = wait_q;
    cancel_d   = cancel_q;
    axiiv_d    = 1'b0;
    pay_sel_d  = 1'b0;
    tag_dib_d  = tag_dib_q;
    uerr_d     = 1'b0;

    case (state_q)
      IDLE: begin
        cancel_d = 1'b1;
        if (qual0_c || qual1_c) begin
          grant_d  = (qual0_c && qual1_c) ? ~last_src_q : qual1_c;
          cancel_d = 1'b0;
          wait_d   = '0;
          beat_d   = '0;
          state_d  = WAIT_SLOT;
        end
      end
      WAIT_SLOT: begin
        if (slot_c) begin
          axiiv_d   = 1'b1;
          tag_dib_d = tag_sel_c;
          beat_d    = KW'(1);
          state_d   = STREAM;
        end else if (wait_q == TW'(SLOT_TIMEOUT - 1)) begin
          uerr_d   = 1'b1;
          cancel_d = 1'b1;
          state_d  = IDLE;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end
      STREAM: begin
        if (slot_c) begin
          if (payload_c && cur_empty_c) begin
            uerr_d   = 1'b1;
            cancel_d = 1'b1;
            state_d  = IDLE;
          end else begin
            axiiv_d   = 1'b1;
            pay_sel_d = payload_c;
            if (!payload_c) tag_dib_d = tag_sel_c;
            beat_d = beat_q + KW'(1);
            if (last_beat_c) state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Leave only once the packer stalls into its checksum tail.
        if (done_c) begin
          if (grant_q) seq1_d = seq1_q + SEQ_W'(1);
          else         seq0_d = seq0_q + SEQ_W'(1);
          last_src_d = grant_q;
          cancel_d   = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      last_src_q <= 1'b1;
      seq0_q     <= '0;
      seq1_q     <= '0;
      beat_q     <= '0;
      wait_q     <= '0;
      cancel_q   <= 1'b1;
      axiiv_q    <= 1'b0;
      pay_sel_q  <= 1'b0;
      tag_dib_q  <= '0;
      uerr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_src_q <= last_src_d;
      seq0_q     <= seq0_d;
      seq1_q     <= seq1_d;
      beat_q     <= beat_d;
      wait_q     <= wait_d;
      cancel_q   <= cancel_d;
      axiiv_q    <= axiiv_d;
      pay_sel_q  <= pay_sel_d;
      tag_dib_q  <= tag_dib_d;
      uerr_q     <= uerr_d;
      busy_q     <= busy_d;
    end
  end

`ifdef ETH_TX_SCHED_STATS_EN
  logic [15:0] pkt_cnt0_q, pkt_cnt1_q;
  logic [7:0]  err_cnt_q;

  // Saturating completed-packet and error-pulse counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt0_q <= '0;
      pkt_cnt1_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (done_c && !grant_q && (pkt_cnt0_q != 16'hFFFF)) pkt_cnt0_q <= pkt_cnt0_q + 16'd1;
      if (done_c && grant_q && (pkt_cnt1_q != 16'hFFFF))  pkt_cnt1_q <= pkt_cnt1_q + 16'd1;
      if (uerr_d && (err_cnt_q != 8'hFF))                 err_cnt_q  <= err_cnt_q + 8'd1;
    end
  end

  assign pkt_cnt0 = pkt_cnt0_q;
  assign pkt_cnt1 = pkt_cnt1_q;
  assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_eth_tx_scheduler.sv
// Directed bench for eth_tx_scheduler with a reduced packet length; FIFO and packer are modelled cycle by cycle.
module tb_eth_tx_scheduler;

  localparam int unsigned PKT = 64;
  localparam int unsigned CW  = 13;
  localparam int unsigned TMO = 4096;
  localparam int unsigned THR = PKT - 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  eth_tx_scheduler_if #(.CNT_W(CW)) bus ();

`ifdef ETH_TX_SCHED_STATS_EN
  logic [15:0] pkt_cnt0, pkt_cnt1;
  logic [7:0]  err_cnt;
`endif

  eth_tx_scheduler #(
    .PKT_DIBITS  (PKT),
    .CNT_W       (CW),
    .SLOT_TIMEOUT(TMO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
`ifdef ETH_TX_SCHED_STATS_EN
    ,
    .pkt_cnt0(pkt_cnt0),
    .pkt_cnt1(pkt_cnt1),
    .err_cnt (err_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;
  int nbeats, nrd0, nrd1, nuerr;
  int both_rd = 0, paybad = 0;
  int pay0 = 0, pay1 = 0, rd0_tot = 0, rd1_tot = 0, bidx = 0;
  logic rd0_seen = 1'b0, rd1_seen = 1'b0, e0_drv = 1'b0;
  logic [7:0] tagv;
  logic [7:0] tagq[$];
`ifdef ETH_TX_SCHED_STATS_EN
  logic [15:0] pc0_before;
`endif

  function automatic logic [1:0] pat(input int j);
    int t;
    t = j ^ (j >> 3);
    return t[1:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive FIFO/packer at negedge, then sample and score the DUT.
  task automatic tick(input logic stall);
    logic [1:0] exp_d;
    @(negedge clk);
    if (rd0_seen) begin bus.src0_data = pat(rd0_tot); rd0_tot++; end
    if (rd1_seen) begin bus.src1_data = pat(rd1_tot); rd1_tot++; end
    bus.src0_empty   = e0_drv;
    bus.packer_stall = stall;
    #1;
    rd0_seen = bus.src0_rd;
    rd1_seen = bus.src1_rd;
    if (rd0_seen) nrd0++;
    if (rd1_seen) nrd1++;
    if (rd0_seen && rd1_seen) both_rd++;
    if (bus.underflow_err) nuerr++;
    if (bus.packer_cancel) begin
      bidx = 0;
    end else if (bus.packer_axiiv) begin
      nbeats++;
      if (bidx < 4) begin
        tagv[2*bidx +: 2] = bus.packer_axiid;
        if (bidx == 3) tagq.push_back(tagv);
      end else begin
        if (bus.active_src) begin exp_d = pat(pay1); pay1++; end
        else                begin exp_d = pat(pay0); pay0++; end
        if (bus.packer_axiid !== exp_d) paybad++;
      end
      bidx++;
    end
  endtask

  task automatic clr();
    nbeats = 0; nrd0 = 0; nrd1 = 0; nuerr = 0;
    tagq.delete();
  endtask

  task automatic wait_grant(input int c0, input int c1, input bit keep);
    int n;
    bus.src0_count = CW'(c0);
    bus.src1_count = CW'(c1);
    n = 0;
    do begin tick(1'b1); n++; end while (bus.packer_cancel !== 1'b0 && n < 20);
    chk("grant_wait", 32'(bus.packer_cancel), 32'd0);
    if (!keep) begin bus.src0_count = '0; bus.src1_count = '0; end
  endtask

  task automatic run_pkt(input int c0, input int c1, input bit keep);
    wait_grant(c0, c1, keep);
    repeat (3) tick(1'b1);
    repeat (PKT + 1) tick(1'b0);
    repeat (2) tick(1'b1);
  endtask

  task automatic run_to_beat(input int b);
    int n;
    n = 0;
    while (bidx != b && n < 4 * PKT) begin tick(1'b0); n++; end
    chk("reach_beat", 32'(bidx), 32'(b));
  endtask

  initial begin
    bus.src0_count = '0; bus.src1_count = '0;
    bus.src0_empty = 1'b0; bus.src1_empty = 1'b0;
    bus.src0_data = '0; bus.src1_data = '0;
    bus.packer_stall = 1'b1;
    clr();

    // reset values
    #1 rst_n = 1'b0;
    repeat (2) tick(1'b1);
    chk("rst_cancel", 32'(bus.packer_cancel), 32'd1);
    chk("rst_axiiv",  32'(bus.packer_axiiv),  32'd0);
    chk("rst_axiid",  32'(bus.packer_axiid),  32'd0);
    chk("rst_rd",     32'({bus.src1_rd, bus.src0_rd}), 32'd0);
    chk("rst_busy",   32'(bus.busy),          32'd0);
    chk("rst_src",    32'(bus.active_src),    32'd0);
    chk("rst_uerr",   32'(bus.underflow_err), 32'd0);
    rst_n = 1'b1;

    // one below threshold does not qualify
    bus.src0_count = CW'(THR - 1);
    repeat (4) tick(1'b1);
    chk("below_thr_busy",   32'(bus.busy),          32'd0);
    chk("below_thr_cancel", 32'(bus.packer_cancel), 32'd1);

    // single source-0 packet
    clr();
    run_pkt(THR, 0, 1'b0);
    chk("t1_beats",  32'(nbeats), 32'(PKT));
    chk("t1_rd0",    32'(nrd0),   32'(THR));
    chk("t1_rd1",    32'(nrd1),   32'd0);
    chk("t1_ntag",   32'(tagq.size()), 32'd1);
    chk("t1_tag",    32'(tagq[$]), 32'h00);
    chk("t1_cancel", 32'(bus.packer_cancel), 32'd1);
    chk("t1_busy",   32'(bus.busy), 32'd0);
    chk("t1_uerr",   32'(nuerr), 32'd0);

    // both qualified: alternate grants
    clr();
    run_pkt(THR, THR, 1'b1);
    run_pkt(THR, THR, 1'b1);
    run_pkt(THR, THR, 1'b1);
    run_pkt(THR, THR, 1'b0);
    chk("rr_ntag", 32'(tagq.size()), 32'd4);
    chk("rr_tag0", 32'(tagq[0]), 32'h80);
    chk("rr_tag1", 32'(tagq[1]), 32'h01);
    chk("rr_tag2", 32'(tagq[2]), 32'h81);
    chk("rr_tag3", 32'(tagq[3]), 32'h02);
    chk("rr_rd0",  32'(nrd0), 32'(2 * THR));
    chk("rr_rd1",  32'(nrd1), 32'(2 * THR));
    chk("rr_beats", 32'(nbeats), 32'(4 * PKT));

    // source-0 underflow mid-payload
    clr();
    wait_grant(THR, 0, 1'b0);
    run_to_beat(40);
    e0_drv = 1'b1;
    tick(1'b0);
    chk("uf_no_rd", 32'(bus.src0_rd), 32'd0);
    chk("uf_pre",   32'(bus.underflow_err), 32'd0);
    tick(1'b0);
    chk("uf_pulse",  32'(bus.underflow_err), 32'd1);
    chk("uf_cancel", 32'(bus.packer_cancel), 32'd1);
    chk("uf_busy",   32'(bus.busy), 32'd0);
    tick(1'b0);
    chk("uf_pulse_end", 32'(bus.underflow_err), 32'd0);
    repeat (5) tick(1'b0);
    chk("uf_npulse", 32'(nuerr), 32'd1);
    chk("uf_rd0",    32'(nrd0), 32'd37);
    chk("uf_beats",  32'(nbeats), 32'd41);
    e0_drv = 1'b0;
    tick(1'b1);
    clr();
    run_pkt(THR, 0, 1'b0);
    chk("uf_seq_kept", 32'(tagq[$]), 32'h03);

    // slot timeout
    clr();
    wait_grant(THR, 0, 1'b0);
    repeat (TMO - 1) tick(1'b1);
    chk("to_pre",      32'(bus.underflow_err), 32'd0);
    chk("to_pre_busy", 32'(bus.busy), 32'd1);
    tick(1'b1);
    chk("to_pulse",  32'(bus.underflow_err), 32'd1);
    chk("to_cancel", 32'(bus.packer_cancel), 32'd1);
    chk("to_busy",   32'(bus.busy), 32'd0);
    tick(1'b1);
    chk("to_pulse_end", 32'(bus.underflow_err), 32'd0);
    chk("to_beats", 32'(nbeats), 32'd0);
`ifdef ETH_TX_SCHED_STATS_EN
    chk("st_pkt0", 32'(pkt_cnt0), 32'd4);
    chk("st_pkt1", 32'(pkt_cnt1), 32'd2);
    chk("st_err",  32'(err_cnt),  32'd2);
`endif

    // asynchronous reset mid-payload
    clr();
    wait_grant(THR, 0, 1'b0);
    run_to_beat(30);
    chk("rs_pre_rd", 32'(bus.src0_rd), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_rd0",    32'(bus.src0_rd), 32'd0);
    chk("rs_axiiv",  32'(bus.packer_axiiv), 32'd0);
    chk("rs_cancel", 32'(bus.packer_cancel), 32'd1);
    chk("rs_busy",   32'(bus.busy), 32'd0);
    rd0_seen = 1'b0;
    repeat (2) tick(1'b1);
    rst_n = 1'b1;
    clr();
    run_pkt(THR, THR, 1'b1);
    run_pkt(THR, THR, 1'b0);
    chk("rs_ntag", 32'(tagq.size()), 32'd2);
    chk("rs_tag0", 32'(tagq[0]), 32'h00);
    chk("rs_tag1", 32'(tagq[1]), 32'h80);

    // sequence wrap on source 0
    clr();
    for (int i = 0; i < 126; i++) run_pkt(THR, 0, 1'b1);
    chk("wr_tag126", 32'(tagq[$]), 32'h7E);
`ifdef ETH_TX_SCHED_STATS_EN
    pc0_before = pkt_cnt0;
`endif
    run_pkt(THR, 0, 1'b1);
    chk("wr_tag127", 32'(tagq[$]), 32'h7F);
`ifdef ETH_TX_SCHED_STATS_EN
    chk("wr_pkt0_inc", 32'(pkt_cnt0), 32'(pc0_before + 16'd1));
`endif
    run_pkt(THR, 0, 1'b0);
    chk("wr_tag_wrap", 32'(tagq[$]), 32'h00);
    chk("wr_ntag", 32'(tagq.size()), 32'd128);

    chk("never_both_rd", 32'(both_rd), 32'd0);
    chk("payload_data",  32'(paybad),  32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eth_tx_scheduler.md
Name: eth_tx_scheduler

Overview:
- Two-source round-robin scheduler that sequences the Ethernet dibit packer.
- Sources are two dibit FIFOs, e.g. video-strip and control/audio.
- Holds the packer idle via `packer_cancel` until one source holds a full payload, then grants it.
- Prepends a 4-dibit tag (source ID plus sequence number) and streams the payload on the packer's `stall`-low slots, so FPGA2 can demux and detect drops.

Parameters:
- PKT_DIBITS, 5120: dibit beats per packet (tag + payload); equals the packer's data-field length.
- CNT_W, 13: width of source occupancy counts.
- SLOT_TIMEOUT, 4096: max cycles in WAIT_SLOT before abort.

Ports:
- clk  in  1  system clock (50 MHz RMII domain)
- rst_n  in  1  asynchronous, active-low reset
- src0_count  in  CNT_W  source 0 FIFO occupancy in dibits
- src0_empty  in  1  source 0 FIFO empty
- src0_rd  out  1  source 0 read strobe; data valid the following cycle
- src0_data  in  2  source 0 read data
- src1_count, src1_empty, src1_rd, src1_data: as source 0, for source 1
- packer_stall  in  1  packer stall; low = packer accepts a beat next cycle
- packer_axiiv  out  1  beat valid to packer
- packer_axiid  out  2  beat dibit to packer
- packer_cancel  out  1  forces packer to Idle while high
- busy  out  1  high in any state except IDLE
- active_src  out  1  granted source ID
- underflow_err  out  1  one-cycle pulse on mid-packet FIFO underflow or slot timeout

Behaviour:
- Reset (async, rst_n low): all outputs 0 except `packer_cancel`=1; `last_src`=1; both sequence counters 0; state IDLE.
  - `src*_rd` and `packer_axiiv` drop to 0 immediately on rst_n assertion, including mid-packet.
- Qualify: source N qualifies when srcN_count >= PKT_DIBITS-4.
- Arbitration: if both qualify, grant the source that is not `last_src`. If only one qualifies, grant it. `last_src` updates on packet completion only.
- IDLE: `packer_cancel`=1.
  - When any source qualifies: latch grant and tag; next cycle `packer_cancel`=0; go to WAIT_SLOT.
- WAIT_SLOT: count cycles while `packer_stall`=1.
  - On the first `packer_stall`=0 cycle, that cycle is beat 0; go to STREAM.
  - If count reaches SLOT_TIMEOUT: pulse `underflow_err`, assert `packer_cancel`, go to IDLE.
- STREAM: beat counter k advances on each `packer_stall`=0 cycle, up to PKT_DIBITS.
  - Beats k=0..3 (tag): no source read. Tag byte = {src_id, seq[6:0]}, where seq is the per-source sequence counter. Cycle k+1 drives `packer_axiiv`=1 and `packer_axiid`=tag[2k+1:2k] (LS dibit first).
  - Beats k=4..PKT_DIBITS-1 (payload): assert the granted `srcN_rd` in cycle k. Cycle k+1 drives `packer_axiiv`=1 and `packer_axiid`=`srcN_data`, combinational from the FIFO.
  - A `packer_stall`=1 cycle inside the packet issues no read; the following cycle has `packer_axiiv`=0.
  - After PKT_DIBITS beats, go to DRAIN. The extra `stall`-low cycle the packer produces per packet produces no read and `axiiv`=0.
- DRAIN: `packer_axiiv`=0; wait for `packer_stall`=1.
  - Then: increment the granted source's seq (7-bit, wraps 127->0), set `last_src`=grant, `packer_cancel`=1, go to IDLE. Cancel takes effect after the packer's checksum tail, since the packer only leaves SendTail via its own counter while `stall` is high.
- Underflow: if a payload read is due while the granted `src_empty`=1:
  - no read;
  - pulse `underflow_err`;
  - `packer_cancel`=1 from the next cycle;
  - go to IDLE;
  - seq is not incremented and `last_src` is unchanged.
- The non-granted source is never read. At most one `src*_rd` is high in any cycle.
- Never more than PKT_DIBITS `packer_axiiv` beats per packet.

Optional Feature:
- Macro: ETH_TX_SCHED_STATS_EN.
- Defined adds three outputs:
  - `pkt_cnt0` [15:0] and `pkt_cnt1` [15:0]: completed packets per source, incremented in DRAIN exit, saturating at 16'hFFFF;
  - `err_cnt` [7:0]: `underflow_err` pulses, saturating at 8'hFF.
  - All reset to 0 asynchronously.
- Undefined: these ports and registers are absent; the rest of the behaviour is identical.

Test Plan:
- Source 0 count=5116, source 1 count=0, packer model with stall low for 5121 cycles -> exactly 5120 `axiiv` beats; first 4 dibits 00,00,00,00 (tag 8'h00); 5116 `src0_rd`; then `seq0`=1 and `packer_cancel`=1 after stall rises.
- Both sources qualified for 4 consecutive packets -> grant order 0,1,0,1; second source-1 tag = 8'h81 (dibits 01,00,00,10).
- Source 0 count=5116 but `src0_empty` forced high at beat 1000 -> `underflow_err` single pulse; no further `src0_rd`; `packer_cancel`=1 next cycle; next packet's tag seq unchanged.
- Source qualified, `packer_stall` held high for 4096 cycles -> `underflow_err` pulse, `packer_cancel`=1, state IDLE, `busy`=0.
- rst_n asserted at beat 2500 -> same cycle `src0_rd`=0, `packer_axiiv`=0, `packer_cancel`=1; after release, seq counters 0 and source 0 wins first arbitration.
- Source 0 seq at 127, one packet sent -> tag 8'h7F sent, seq wraps to 0; with ETH_TX_SCHED_STATS_EN, `pkt_cnt0` increments by 1.
